// File: rtl/cv_datadecp.sv
// cv_datadecp: pipelined TMDS receive-channel decoder with token-based word alignment.
// Three register stages from din to outputs; alignment FSM emits bitslip until lock.
// Optional build macro: CV_DATADEC_CODECHK_EN enables the received-code legality check (code_err).
module cv_datadecp #(
    parameter int unsigned TOKEN_RUN  = 4,
    parameter int unsigned SEARCH_LEN = 4096,
    parameter int unsigned SLIP_WAIT  = 16,
    parameter int unsigned LOSS_LEN   = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [9:0] din,
    input  logic       din_en,
    output logic [7:0] dout,
    output logic [1:0] ctl,
    output logic       de,
    output logic       dout_en,
    output logic       code_err,
    output logic       bitslip,
    output logic       locked
);

    localparam int unsigned RUN_W    = $clog2(TOKEN_RUN) + 1;
    localparam int unsigned SEARCH_W = $clog2(SEARCH_LEN) + 1;
    localparam int unsigned SLIP_W   = $clog2(SLIP_WAIT) + 1;
    localparam int unsigned LOSS_W   = $clog2(LOSS_LEN) + 1;

    localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(TOKEN_RUN);
    localparam logic [SEARCH_W-1:0] SEARCH_MAX = SEARCH_W'(SEARCH_LEN);
    localparam logic [SLIP_W-1:0]   SLIP_MAX   = SLIP_W'(SLIP_WAIT);
    localparam logic [LOSS_W-1:0]   LOSS_MAX   = LOSS_W'(LOSS_LEN);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SLIP = 2'd1,
        LOCK = 2'd2
    } state_t;

    // stage 1
    logic       tok_c;
    logic [1:0] tcode_c;
    logic [9:0] s1_din;
    logic       s1_en;
    logic       s1_tok;
    logic [1:0] s1_tcode;

    // stage 2
    logic [7:0] q_c;
    logic [7:0] d_c;
    logic [7:0] s2_d;
    logic       s2_en;
    logic       s2_tok;
    logic [1:0] s2_tcode;

    // alignment FSM
    state_t              state_q, state_d;
    logic [RUN_W-1:0]    run_q, run_d, run_inc;
    logic [SEARCH_W-1:0] search_q, search_d, search_inc;
    logic [SLIP_W-1:0]   slip_q, slip_d, slip_inc;
    logic [LOSS_W-1:0]   loss_q, loss_d, loss_inc;
    logic                bitslip_c;

    // Recognise the four control tokens on the raw symbol
    always_comb begin
        tok_c   = 1'b0;
        tcode_c = 2'b00;
        case (din)
            10'b1101010100: begin tok_c = 1'b1; tcode_c = 2'b00; end
            10'b0010101011: begin tok_c = 1'b1; tcode_c = 2'b01; end
            10'b0101010100: begin tok_c = 1'b1; tcode_c = 2'b10; end
            10'b1010101011: begin tok_c = 1'b1; tcode_c = 2'b11; end
            default:        begin tok_c = 1'b0; tcode_c = 2'b00; end
        endcase
    end

    // Stage 1: capture symbol, valid and token classification
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_din   <= '0;
            s1_en    <= 1'b0;
            s1_tok   <= 1'b0;
            s1_tcode <= 2'b00;
        end else begin
            s1_din   <= din;
            s1_en    <= din_en;
            s1_tok   <= tok_c;
            s1_tcode <= tcode_c;
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        q_c    = s1_din[9] ? ~s1_din[7:0] : s1_din[7:0];
        d_c    = '0;
        d_c[0] = q_c[0];
        for (int i = 1; i < 8; i++) begin
            d_c[i] = s1_din[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
        end
    end

    // Stage 2: capture decoded byte alongside the token side-band
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_d     <= '0;
            s2_en    <= 1'b0;
            s2_tok   <= 1'b0;
            s2_tcode <= 2'b00;
        end else begin
            s2_d     <= d_c;
            s2_en    <= s1_en;
            s2_tok   <= s1_tok;
            s2_tcode <= s1_tcode;
        end
    end

    // Stage 3: output register; ctl keeps the last token code across data words
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout    <= '0;
            ctl     <= 2'b00;
            de      <= 1'b0;
            dout_en <= 1'b0;
        end else begin
            dout_en <= s2_en;
            if (s2_tok) begin
                de   <= 1'b0;
                ctl  <= s2_tcode;
                dout <= '0;
            end else begin
                de   <= 1'b1;
                dout <= s2_d;
            end
        end
    end

`ifdef CV_DATADEC_CODECHK_EN
    logic       s2_din8;
    logic [3:0] n1_c;
    logic       use_xnor_c;

    // Carry the received q_m[8] into stage 2 for the legality check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_din8 <= 1'b0;
        end else begin
            s2_din8 <= s1_din[8];
        end
    end

    // Recompute the encoder's XOR/XNOR decision from the decoded byte
    always_comb begin
        n1_c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_c = n1_c + 4'(s2_d[i]);
        end
        use_xnor_c = (n1_c > 4'd4) | ((n1_c == 4'd4) & ~s2_d[0]);
    end

    // A legal symbol carries q_m[8] = ~use_xnor; tokens are never flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_err <= 1'b0;
        end else begin
            code_err <= ~s2_tok & (s2_din8 == use_xnor_c);
        end
    end
`else
    assign code_err = 1'b0;
`endif

    // Saturating increments of every FSM counter
    always_comb begin
        run_inc    = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        search_inc = (search_q == SEARCH_MAX) ? search_q : search_q + SEARCH_W'(1);
        slip_inc   = (slip_q == SLIP_MAX) ? slip_q : slip_q + SLIP_W'(1);
        loss_inc   = (loss_q == LOSS_MAX) ? loss_q : loss_q + LOSS_W'(1);
    end

    // Alignment next-state; steps only on enabled stage-1 words while cs is high.
    // A code_err word is never a token, so it already counts against the loss counter.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        search_d  = search_q;
        slip_d    = slip_q;
        loss_d    = loss_q;
        bitslip_c = 1'b0;
        if (!cs) begin
            state_d  = HUNT;
            run_d    = '0;
            search_d = '0;
            slip_d   = '0;
            loss_d   = '0;
        end else if (s1_en) begin
            case (state_q)
                HUNT: begin
                    run_d    = s1_tok ? run_inc : '0;
                    search_d = search_inc;
                    if (s1_tok && (run_inc == RUN_MAX)) begin
                        // lock takes priority over a coincident search expiry
                        state_d  = LOCK;
                        run_d    = '0;
                        search_d = '0;
                        loss_d   = '0;
                    end else if (search_inc == SEARCH_MAX) begin
                        state_d   = SLIP;
                        bitslip_c = 1'b1;
                        run_d     = '0;
                        search_d  = '0;
                        slip_d    = '0;
                    end
                end
                SLIP: begin
                    slip_d = slip_inc;
                    if (slip_inc == SLIP_MAX) begin
                        state_d  = HUNT;
                        slip_d   = '0;
                        run_d    = '0;
                        search_d = '0;
                    end
                end
                LOCK: begin
                    loss_d = s1_tok ? '0 : loss_inc;
                    if (!s1_tok && (loss_inc == LOSS_MAX)) begin
                        state_d  = HUNT;
                        loss_d   = '0;
                        run_d    = '0;
                        search_d = '0;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    run_d    = '0;
                    search_d = '0;
                    slip_d   = '0;
                    loss_d   = '0;
                end
            endcase
        end
    end

    // FSM state, counters and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HUNT;
            run_q    <= '0;
            search_q <= '0;
            slip_q   <= '0;
            loss_q   <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            search_q <= search_d;
            slip_q   <= slip_d;
            loss_q   <= loss_d;
            bitslip  <= bitslip_c;
            locked   <= (state_d == LOCK);
        end
    end

endmodule

// File: tb/tb_cv_datadecp.sv
// Testbench for cv_datadecp: table-driven decode vectors plus directed alignment sequences.
module tb_cv_datadecp;

    localparam int unsigned TOKEN_RUN  = 4;
    localparam int unsigned SEARCH_LEN = 64;
    localparam int unsigned SLIP_WAIT  = 16;
    localparam int unsigned LOSS_LEN   = 32;

`ifdef CV_DATADEC_CODECHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0;
    logic [9:0] din = '0;
    logic       din_en = 1'b0;
    logic [7:0] dout;
    logic [1:0] ctl;
    logic       de;
    logic       dout_en;
    logic       code_err;
    logic       bitslip;
    logic       locked;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cv_datadecp #(
        .TOKEN_RUN (TOKEN_RUN),
        .SEARCH_LEN(SEARCH_LEN),
        .SLIP_WAIT (SLIP_WAIT),
        .LOSS_LEN  (LOSS_LEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .din     (din),
        .din_en  (din_en),
        .dout    (dout),
        .ctl     (ctl),
        .de      (de),
        .dout_en (dout_en),
        .code_err(code_err),
        .bitslip (bitslip),
        .locked  (locked)
    );

    typedef struct {
        logic [9:0] sym;
        logic       en;
        logic       x_en;
        logic       x_de;
        logic [1:0] x_ctl;
        logic [7:0] x_dout;
        logic       x_err;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [9:0] s, input logic e);
        din    = s;
        din_en = e;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cs      = 1'b0;
        drive(10'h100, 1'b0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Reference TMDS data encoder; inv selects the inverted (bit9=1) form
    function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
        int         n1;
        logic       xn;
        logic [7:0] qm;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(b[i]);
        xn    = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
        qm    = '0;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        return inv ? {1'b1, ~xn, ~qm} : {1'b0, ~xn, qm};
    endfunction

    initial begin
        vec_t       tab[12];
        logic       en_q[$];
        logic [7:0] b_q[$];
        int         b;
        logic       e;
        logic [7:0] eb;
        logic [9:0] w;

        // ---------------- reset: all outputs low while held ----------------
        reset_n = 1'b0;
        cs      = 1'b1;
        drive(10'b1101010100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("reset_outputs", {dout, ctl, de, dout_en, code_err, bitslip, locked}, 32'd0);
        end

        // ---------------- latency: token at cycle 0 appears at cycle 3 ----------------
        cs      = 1'b0;
        reset_n = 1'b1;
        drive(10'b1101010100, 1'b1);
        step();
        check("lat_c1_en", dout_en, 0);
        drive(10'h100, 1'b0);
        step();
        check("lat_c2_en", dout_en, 0);
        step();
        check("lat_c3", {dout_en, de, ctl}, {28'd0, 1'b1, 1'b0, 2'b00});

        // ---------------- table-driven decode vectors ----------------
        tab[0]  = '{10'b1101010100, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0};
        tab[1]  = '{10'h100,        1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0};
        tab[2]  = '{10'b0010101011, 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 1'b0};
        tab[3]  = '{10'h0FF,        1'b1, 1'b1, 1'b1, 2'b01, 8'hFF, 1'b0};
        tab[4]  = '{10'b0101010100, 1'b1, 1'b1, 1'b0, 2'b10, 8'h00, 1'b0};
        tab[5]  = '{10'h200,        1'b1, 1'b1, 1'b1, 2'b10, 8'hFF, 1'b0};
        tab[6]  = '{10'b1010101011, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 1'b0};
        tab[7]  = '{10'h1F0,        1'b1, 1'b1, 1'b1, 2'b11, 8'h10, 1'b0};
        tab[8]  = '{10'h30F,        1'b0, 1'b0, 1'b1, 2'b11, 8'h10, 1'b0};
        tab[9]  = '{10'h1FF,        1'b1, 1'b1, 1'b1, 2'b11, 8'h01, 1'b0};
        tab[10] = '{10'h155,        1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, CHK};
        tab[11] = '{10'b1101010100, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0};

        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(tab[i].sym, tab[i].en);
            else        drive(10'h100, 1'b0);
            step();
            if (i >= 2) begin
                check($sformatf("vec%0d", i - 2),
                      {19'd0, dout_en, de, ctl, dout, code_err},
                      {19'd0, tab[i-2].x_en, tab[i-2].x_de, tab[i-2].x_ctl,
                       tab[i-2].x_dout, tab[i-2].x_err});
            end
        end

        // ---------------- round trip of every byte with enable gaps ----------------
        b = 0;
        for (int c = 0; c < 330; c++) begin
            if (b < 256 && (c % 5) != 4) begin
                drive(enc(8'(b), b[0]), 1'b1);
                en_q.push_back(1'b1);
                b_q.push_back(8'(b));
                b++;
            end else begin
                drive(enc(8'hA5, 1'b0), 1'b0);
                en_q.push_back(1'b0);
                b_q.push_back(8'h00);
            end
            step();
            if (en_q.size() == 3) begin
                e  = en_q.pop_front();
                eb = b_q.pop_front();
                if (e) check("roundtrip", {dout_en, de, dout, code_err}, {21'd0, 1'b1, 1'b1, eb, 1'b0});
                else   check("roundtrip_gap_en", dout_en, 0);
            end
        end
        check("roundtrip_count", b, 256);

        // ---------------- lock on 4 tokens, then loss after 32 data words ----------------
        do_reset();
        cs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(10'b0010101011, 1'b1);
            step();
            check("lock_pre", {bitslip, locked}, 0);
        end
        for (int j = 1; j <= 34; j++) begin
            drive(enc(8'(j), 1'b0), 1'b1);
            step();
            check($sformatf("lock_loss_w%0d", j), {bitslip, locked}, {30'd0, 1'b0, (j <= 32)});
        end

        // ---------------- cs low mid-LOCK ----------------
        do_reset();
        cs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(10'b1101010100, 1'b1);
            step();
        end
        check("cs_locked_before", locked, 1);
        cs = 1'b0;
        drive(10'b1101010100, 1'b1);
        step();
        check("cs_drop", {bitslip, locked}, 0);
        for (int i = 0; i < 70; i++) begin
            drive(enc(8'(i), 1'b1), 1'b1);
            step();
            check("cs_idle", {bitslip, locked}, 0);
        end

        // ---------------- bitslip cadence; tokens ignored during settle ----------------
        do_reset();
        cs = 1'b1;
        for (int n = 1; n <= 150; n++) begin
            w = (n >= 65 && n <= 80) ? 10'b1101010100 : enc(8'(n), n[0]);
            drive(w, 1'b1);
            step();
            check($sformatf("slip_n%0d", n), {bitslip, locked}, {30'd0, (n == 65 || n == 145), 1'b0});
        end

        // ---------------- search expiry and run completion on the same word ----------------
        do_reset();
        cs = 1'b1;
        for (int n = 1; n <= 68; n++) begin
            w = (n >= 61 && n <= 64) ? 10'b1010101011 : enc(8'(n + 7), 1'b0);
            drive(w, 1'b1);
            step();
            check($sformatf("tie_n%0d", n), {bitslip, locked}, {30'd0, 1'b0, (n >= 65)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
